// File: rtl/param_stack.sv
// Parametrised LIFO operand stack. The top two entries live in registers so
// both ALU operands are available together; deeper entries sit in mem.
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] nos,
    output logic [WIDTH-1:0] d_out,
    output logic [WIDTH-1:0] d_out2,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             err,
    output logic             err_sticky
);

    localparam int AW = $clog2(DEPTH - 2);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_POP2  = 3'b011;
    localparam logic [2:0] OP_DUP   = 3'b100;
    localparam logic [2:0] OP_SWAP  = 3'b101;
    localparam logic [2:0] OP_REPL  = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C1     = CW'(1);
    localparam logic [CW-1:0] C2     = CW'(2);
    localparam logic [CW-1:0] C3     = CW'(3);
    localparam logic [CW-1:0] C4     = CW'(4);

    logic [WIDTH-1:0] mem [0:DEPTH-3];

    logic [WIDTH-1:0] top_q, nos_q, d_out_q, d_out2_q;
    logic [CW-1:0]    count_q;
    logic             err_q, sticky_q;

    logic has1, has2, has3, has4, not_full, legal;
    logic [AW-1:0]    idx2, idx3, idx4;
    logic [WIDTH-1:0] mem3, mem4;

    assign has1     = count_q >= C1;
    assign has2     = count_q >= C2;
    assign has3     = count_q >= C3;
    assign has4     = count_q >= C4;
    assign not_full = count_q != C_FULL;

    // Index arithmetic wraps in AW bits; results are only consumed when in range.
    assign idx2 = AW'(count_q) - AW'(2);
    assign idx3 = AW'(count_q) - AW'(3);
    assign idx4 = AW'(count_q) - AW'(4);
    assign mem3 = mem[idx3];
    assign mem4 = mem[idx4];

    always_comb begin
        legal = 1'b1;
        case (op)
            OP_PUSH: legal = not_full;
            OP_POP:  legal = has1;
            OP_POP2: legal = has2;
            OP_DUP:  legal = has1 && not_full;
            OP_SWAP: legal = has2;
            OP_REPL: legal = has1;
            default: legal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q    <= '0;
            nos_q    <= '0;
            d_out_q  <= '0;
            d_out2_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            err_q <= ~legal;
            if (!legal) begin
                sticky_q <= 1'b1;
            end else begin
                case (op)
                    OP_PUSH: begin
                        nos_q   <= top_q;
                        top_q   <= d_in;
                        count_q <= count_q + C1;
                    end
                    OP_POP: begin
                        d_out_q <= top_q;
                        top_q   <= nos_q;
                        if (has3) nos_q <= mem3;
                        count_q <= count_q - C1;
                    end
                    OP_POP2: begin
                        d_out_q  <= top_q;
                        d_out2_q <= nos_q;
                        if (has3) top_q <= mem3;
                        if (has4) nos_q <= mem4;
                        count_q  <= count_q - C2;
                    end
                    OP_DUP: begin
                        nos_q   <= top_q;
                        count_q <= count_q + C1;
                    end
                    OP_SWAP: begin
                        top_q <= nos_q;
                        nos_q <= top_q;
                    end
                    OP_REPL: top_q <= d_in;
                    OP_CLEAR: begin
                        count_q  <= '0;
                        sticky_q <= 1'b0;
                    end
                    OP_NOP:  ;
                    default: ;
                endcase
            end
        end
    end

    // Spill nos into the array whenever a push-type op deepens the stack past two.
    always_ff @(posedge clk) begin
        if (legal && (op == OP_PUSH || op == OP_DUP) && has2)
            mem[idx2] <= nos_q;
    end

    assign top        = has1 ? top_q : '0;
    assign nos        = has2 ? nos_q : '0;
    assign d_out      = d_out_q;
    assign d_out2     = d_out2_q;
    assign count      = count_q;
    assign empty      = count_q == '0;
    assign full       = count_q == C_FULL;
    assign err        = err_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack: a default-size instance and a DEPTH=4 instance,
// driven from vector tables and a reference LIFO model through a scoreboard.
module tb_param_stack;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0] op_a, op_b;
    logic [7:0] din_a, din_b;
    logic [7:0] top_a, nos_a, dout_a, dout2_a;
    logic [7:0] top_b, nos_b, dout_b, dout2_b;
    logic [8:0] cnt_a;
    logic [2:0] cnt_b;
    logic empty_a, full_a, err_a, st_a;
    logic empty_b, full_b, err_b, st_b;

    param_stack dut_a (
        .clk(clk), .rst(rst), .op(op_a), .d_in(din_a),
        .top(top_a), .nos(nos_a), .d_out(dout_a), .d_out2(dout2_a),
        .count(cnt_a), .empty(empty_a), .full(full_a),
        .err(err_a), .err_sticky(st_a)
    );

    param_stack #(.WIDTH(8), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .op(op_b), .d_in(din_b),
        .top(top_b), .nos(nos_b), .d_out(dout_b), .d_out2(dout2_b),
        .count(cnt_b), .empty(empty_b), .full(full_b),
        .err(err_b), .err_sticky(st_b)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] d;
        logic [7:0] top, nos, dout, dout2;
        int         cnt;
        logic       err, sticky;
    } vec_t;

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t sb[$];
    vec_t ta[$];
    vec_t tb[$];

    logic [7:0] mq[$];
    logic [7:0] m_dout, m_dout2;
    logic       m_sticky;

    function automatic vec_t mk(logic [2:0] op, logic [7:0] d, logic [7:0] t, logic [7:0] n,
                                logic [7:0] o, logic [7:0] o2, int c, logic e, logic s);
        vec_t v;
        v.op = op; v.d = d; v.top = t; v.nos = n; v.dout = o; v.dout2 = o2;
        v.cnt = c; v.err = e; v.sticky = s;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check(input bit sel, input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if (!sel) begin
            cmp({tag, ".top"},    32'(top_a),   32'(e.top));
            cmp({tag, ".nos"},    32'(nos_a),   32'(e.nos));
            cmp({tag, ".d_out"},  32'(dout_a),  32'(e.dout));
            cmp({tag, ".d_out2"}, 32'(dout2_a), 32'(e.dout2));
            cmp({tag, ".count"},  32'(cnt_a),   32'(e.cnt));
            cmp({tag, ".empty"},  32'(empty_a), 32'(e.cnt == 0));
            cmp({tag, ".full"},   32'(full_a),  32'(e.cnt == 256));
            cmp({tag, ".err"},    32'(err_a),   32'(e.err));
            cmp({tag, ".sticky"}, 32'(st_a),    32'(e.sticky));
        end else begin
            cmp({tag, ".top"},    32'(top_b),   32'(e.top));
            cmp({tag, ".nos"},    32'(nos_b),   32'(e.nos));
            cmp({tag, ".d_out"},  32'(dout_b),  32'(e.dout));
            cmp({tag, ".d_out2"}, 32'(dout2_b), 32'(e.dout2));
            cmp({tag, ".count"},  32'(cnt_b),   32'(e.cnt));
            cmp({tag, ".empty"},  32'(empty_b), 32'(e.cnt == 0));
            cmp({tag, ".full"},   32'(full_b),  32'(e.cnt == 4));
            cmp({tag, ".err"},    32'(err_b),   32'(e.err));
            cmp({tag, ".sticky"}, 32'(st_b),    32'(e.sticky));
        end
    endtask

    task automatic apply(input bit sel, input vec_t v, input string tag);
        @(negedge clk);
        if (sel) begin op_b = v.op; din_b = v.d; end
        else     begin op_a = v.op; din_a = v.d; end
        sb.push_back(v);
        @(posedge clk);
        #1;
        op_a = 3'd0;
        op_b = 3'd0;
        check(sel, tag);
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = 8'h00; m_dout2 = 8'h00; m_sticky = 1'b0;
    endtask

    // Reference LIFO with DEPTH=256; mq[$] is the top of stack.
    task automatic model(input logic [2:0] op, input logic [7:0] d, output vec_t e);
        int c;
        bit ok;
        logic [7:0] t;
        c = mq.size();
        case (op)
            3'd1:    ok = c < 256;
            3'd2:    ok = c >= 1;
            3'd3:    ok = c >= 2;
            3'd4:    ok = c >= 1 && c < 256;
            3'd5:    ok = c >= 2;
            3'd6:    ok = c >= 1;
            default: ok = 1'b1;
        endcase
        if (!ok) m_sticky = 1'b1;
        else begin
            case (op)
                3'd1: mq.push_back(d);
                3'd2: m_dout = mq.pop_back();
                3'd3: begin m_dout = mq.pop_back(); m_dout2 = mq.pop_back(); end
                3'd4: begin t = mq[c-1]; mq.push_back(t); end
                3'd5: begin t = mq[c-1]; mq[c-1] = mq[c-2]; mq[c-2] = t; end
                3'd6: mq[c-1] = d;
                3'd7: begin mq.delete(); m_sticky = 1'b0; end
                default: ;
            endcase
        end
        c = mq.size();
        e = mk(op, d, (c >= 1) ? mq[c-1] : 8'h00, (c >= 2) ? mq[c-2] : 8'h00,
               m_dout, m_dout2, c, !ok, m_sticky);
    endtask

    initial begin
        vec_t e;
        rst = 1'b1;
        op_a = 3'd0; op_b = 3'd0; din_a = 8'h00; din_b = 8'h00;

        // op, d_in, top, nos, d_out, d_out2, count, err, sticky
        ta.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        ta.push_back(mk(3'd1, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00, 1, 0, 0));
        ta.push_back(mk(3'd1, 8'h07, 8'h07, 8'h05, 8'h00, 8'h00, 2, 0, 0));
        ta.push_back(mk(3'd1, 8'h09, 8'h09, 8'h07, 8'h00, 8'h00, 3, 0, 0));
        ta.push_back(mk(3'd2, 8'h00, 8'h07, 8'h05, 8'h09, 8'h00, 2, 0, 0));
        ta.push_back(mk(3'd2, 8'h00, 8'h05, 8'h00, 8'h07, 8'h00, 1, 0, 0));
        ta.push_back(mk(3'd2, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 0, 0, 0));
        ta.push_back(mk(3'd1, 8'h03, 8'h03, 8'h00, 8'h05, 8'h00, 1, 0, 0));
        ta.push_back(mk(3'd1, 8'h08, 8'h08, 8'h03, 8'h05, 8'h00, 2, 0, 0));
        ta.push_back(mk(3'd1, 8'h02, 8'h02, 8'h08, 8'h05, 8'h00, 3, 0, 0));
        ta.push_back(mk(3'd3, 8'h00, 8'h03, 8'h00, 8'h02, 8'h08, 1, 0, 0));
        ta.push_back(mk(3'd5, 8'h00, 8'h03, 8'h00, 8'h02, 8'h08, 1, 1, 1));
        ta.push_back(mk(3'd0, 8'h00, 8'h03, 8'h00, 8'h02, 8'h08, 1, 0, 1));
        ta.push_back(mk(3'd2, 8'h00, 8'h00, 8'h00, 8'h03, 8'h08, 0, 0, 1));
        ta.push_back(mk(3'd1, 8'h06, 8'h06, 8'h00, 8'h03, 8'h08, 1, 0, 1));
        ta.push_back(mk(3'd1, 8'h04, 8'h04, 8'h06, 8'h03, 8'h08, 2, 0, 1));
        ta.push_back(mk(3'd5, 8'h00, 8'h06, 8'h04, 8'h03, 8'h08, 2, 0, 1));
        ta.push_back(mk(3'd4, 8'h00, 8'h06, 8'h06, 8'h03, 8'h08, 3, 0, 1));
        ta.push_back(mk(3'd6, 8'hAA, 8'hAA, 8'h06, 8'h03, 8'h08, 3, 0, 1));
        ta.push_back(mk(3'd3, 8'h00, 8'h04, 8'h00, 8'hAA, 8'h06, 1, 0, 1));
        ta.push_back(mk(3'd7, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h06, 0, 0, 0));
        ta.push_back(mk(3'd2, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h06, 0, 1, 1));
        ta.push_back(mk(3'd6, 8'h55, 8'h00, 8'h00, 8'hAA, 8'h06, 0, 1, 1));
        ta.push_back(mk(3'd4, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h06, 0, 1, 1));
        ta.push_back(mk(3'd7, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h06, 0, 0, 0));
        ta.push_back(mk(3'd1, 8'h21, 8'h21, 8'h00, 8'hAA, 8'h06, 1, 0, 0));
        ta.push_back(mk(3'd3, 8'h00, 8'h21, 8'h00, 8'hAA, 8'h06, 1, 1, 1));
        ta.push_back(mk(3'd1, 8'h22, 8'h22, 8'h21, 8'hAA, 8'h06, 2, 0, 1));
        ta.push_back(mk(3'd3, 8'h00, 8'h00, 8'h00, 8'h22, 8'h21, 0, 0, 1));
        ta.push_back(mk(3'd5, 8'h00, 8'h00, 8'h00, 8'h22, 8'h21, 0, 1, 1));
        ta.push_back(mk(3'd7, 8'h00, 8'h00, 8'h00, 8'h22, 8'h21, 0, 0, 0));
        ta.push_back(mk(3'd1, 8'h01, 8'h01, 8'h00, 8'h22, 8'h21, 1, 0, 0));
        ta.push_back(mk(3'd1, 8'h02, 8'h02, 8'h01, 8'h22, 8'h21, 2, 0, 0));
        ta.push_back(mk(3'd1, 8'h03, 8'h03, 8'h02, 8'h22, 8'h21, 3, 0, 0));
        ta.push_back(mk(3'd1, 8'h04, 8'h04, 8'h03, 8'h22, 8'h21, 4, 0, 0));
        ta.push_back(mk(3'd1, 8'h05, 8'h05, 8'h04, 8'h22, 8'h21, 5, 0, 0));
        ta.push_back(mk(3'd3, 8'h00, 8'h03, 8'h02, 8'h05, 8'h04, 3, 0, 0));
        ta.push_back(mk(3'd2, 8'h00, 8'h02, 8'h01, 8'h03, 8'h04, 2, 0, 0));
        ta.push_back(mk(3'd2, 8'h00, 8'h01, 8'h00, 8'h02, 8'h04, 1, 0, 0));

        tb.push_back(mk(3'd1, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1, 0, 0));
        tb.push_back(mk(3'd1, 8'h02, 8'h02, 8'h01, 8'h00, 8'h00, 2, 0, 0));
        tb.push_back(mk(3'd1, 8'h03, 8'h03, 8'h02, 8'h00, 8'h00, 3, 0, 0));
        tb.push_back(mk(3'd1, 8'h04, 8'h04, 8'h03, 8'h00, 8'h00, 4, 0, 0));
        tb.push_back(mk(3'd1, 8'h05, 8'h04, 8'h03, 8'h00, 8'h00, 4, 1, 1));
        tb.push_back(mk(3'd0, 8'h00, 8'h04, 8'h03, 8'h00, 8'h00, 4, 0, 1));
        tb.push_back(mk(3'd4, 8'h00, 8'h04, 8'h03, 8'h00, 8'h00, 4, 1, 1));
        tb.push_back(mk(3'd2, 8'h00, 8'h03, 8'h02, 8'h04, 8'h00, 3, 0, 1));
        tb.push_back(mk(3'd2, 8'h00, 8'h02, 8'h01, 8'h03, 8'h00, 2, 0, 1));
        tb.push_back(mk(3'd2, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 1, 0, 1));
        tb.push_back(mk(3'd2, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 0, 0, 1));
        tb.push_back(mk(3'd2, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 0, 1, 1));
        tb.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 0, 0, 1));

        #12 rst = 1'b0;

        for (int i = 0; i < ta.size(); i++) apply(1'b0, ta[i], $sformatf("a%0d", i));
        for (int i = 0; i < tb.size(); i++) apply(1'b1, tb[i], $sformatf("b%0d", i));

        // Alternating PUSH/POP against the reference model after loading 10 entries.
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            model(3'd1, 8'($urandom_range(0, 255)), e);
            apply(1'b0, e, $sformatf("load%0d", i));
        end
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) model(3'd1, 8'($urandom_range(0, 255)), e);
            else            model(3'd2, 8'h00, e);
            apply(1'b0, e, $sformatf("alt%0d", i));
        end

        // Build count=5 with err_sticky set, then reset between clock edges.
        model(3'd7, 8'h00, e); apply(1'b0, e, "pre_clr");
        model(3'd2, 8'h00, e); apply(1'b0, e, "pre_err");
        for (int i = 0; i < 5; i++) begin
            model(3'd1, 8'(8'h30 + i), e);
            apply(1'b0, e, $sformatf("pre_push%0d", i));
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        sb.push_back(mk(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0));
        check(1'b0, "async_rst");
        rst = 1'b0;
        model(3'd1, 8'h11, e);
        apply(1'b0, e, "post_rst_push");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/param_stack.md
# param_stack

Parametrised LIFO operand stack for the stack-machine datapath, replacing the fixed 8-bit/256-entry stack. It keeps the top two entries in registers (`top`, `nos`) so the ALU sees both operands in the same cycle, and the remaining entries in an internal array. Single-cycle ops are PUSH, POP, POP2, DUP, SWAP, REPL and CLEAR. Illegal ops (overflow/underflow) are flagged and never corrupt state.

## Interface
- `WIDTH`, default 8: data width in bits.
- `DEPTH`, default 256: maximum entries; legal range ≥ 4.
- `CW`, default `$clog2(DEPTH+1)`: width of `count`; derived, never overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `op`  in  3  operation code, sampled every rising edge (000 = NOP).
- `d_in`  in  WIDTH  data for PUSH/REPL.
- `top`  out  WIDTH  entry count-1 when count ≥ 1, else 0.
- `nos`  out  WIDTH  entry count-2 when count ≥ 2, else 0.
- `d_out`  out  WIDTH  registered; last value removed by POP/POP2 (the old top).
- `d_out2`  out  WIDTH  registered; second value removed by POP2 (the old nos).
- `count`  out  CW  current number of entries, 0..DEPTH.
- `empty`  out  1  count == 0 (combinational from count).
- `full`  out  1  count == DEPTH (combinational from count).
- `err`  out  1  registered one-cycle pulse after an illegal op.
- `err_sticky`  out  1  set by any illegal op; cleared only by CLEAR or rst.

## Operation
- Storage:
  - `top_q` holds entry count-1 and `nos_q` holds entry count-2.
  - `mem[0..DEPTH-3]` holds entries 0..count-3, with `mem[i]` = entry i.
  - `mem` is not reset; its read is combinational.
- Op codes and legality (c = count before the edge):
  - 001 PUSH, legal if c < DEPTH: `mem[c-2]` ← `nos_q` when c ≥ 2; `nos_q` ← `top_q`; `top_q` ← `d_in`; c+1.
  - 010 POP, legal if c ≥ 1: `d_out` ← `top_q`; `top_q` ← `nos_q`; `nos_q` ← `mem[c-3]` when c ≥ 3; c-1.
  - 011 POP2, legal if c ≥ 2: `d_out` ← `top_q`; `d_out2` ← `nos_q`; `top_q` ← `mem[c-3]` when c ≥ 3; `nos_q` ← `mem[c-4]` when c ≥ 4; c-2.
  - 100 DUP, legal if 1 ≤ c < DEPTH: same as PUSH, with `d_in` replaced by `top_q`.
  - 101 SWAP, legal if c ≥ 2: exchange `top_q` and `nos_q`; c unchanged.
  - 110 REPL, legal if c ≥ 1: `top_q` ← `d_in`; c unchanged. This is pop-then-push for writing back an ALU result.
  - 111 CLEAR, always legal: c ← 0; `err_sticky` ← 0.
  - 000 NOP: no change.
- Illegal op: no change to `top_q`, `nos_q`, `mem`, `count`, `d_out` or `d_out2`; `err` ← 1 for one cycle; `err_sticky` ← 1.
- `err` ← 0 after every legal op or NOP.
- Registers not named by an op hold their value. `d_out`/`d_out2` update only on a legal POP/POP2.
- The values left in `top_q`/`nos_q` after the count drops are don't-care internally; the outputs are masked to 0 by count.

## Timing
- Every op completes in one cycle. New `top`, `nos`, `count`, `empty`, `full`, `d_out`, `d_out2` and `err` are visible after the edge that samples `op`.
- Back-to-back ops on consecutive cycles are fully supported; no stall and no busy state.
- PUSH at c = DEPTH-1 → full next cycle. PUSH/DUP while full → err; count stays DEPTH.
- POP at c = 0, POP2 at c ≤ 1, SWAP at c ≤ 1, REPL/DUP at c = 0 → err with no state change.
- POP2 at c = 2 → count 0; `d_out`/`d_out2` hold the two old values.
- Reset values: count 0, `top` 0, `nos` 0, `d_out` 0, `d_out2` 0, `err` 0, `err_sticky` 0, `empty` 1, `full` 0.
- `rst` asserted mid-sequence clears all of the above immediately, regardless of `clk`. `mem` contents are irrelevant after reset.

## Test plan
- Reset, then PUSH 5, PUSH 7, PUSH 9 → count=3, top=9, nos=7; then POP → d_out=9, top=7, nos=5, count=2.
- WIDTH=8, DEPTH=4:
  - PUSH 1, 2, 3, 4 → full=1.
  - PUSH 5 → err=1 for exactly one cycle, err_sticky=1, top=4, count=4.
  - POP ×4 → d_out sequence 4, 3, 2, 1; empty=1.
  - POP once more → err pulse; d_out stays 1.
- Stack [3, 8, 2] (top=2): POP2 → d_out=2, d_out2=8, top=3, nos=0, count=1. Then SWAP → err, state unchanged.
- Stack [6, 4]: SWAP → top=6, nos=4. DUP → top=6, nos=6, count=3. REPL d_in=0xAA → top=0xAA, count=3. CLEAR → count=0, err_sticky=0.
- With 10 entries loaded (DEPTH=256), run alternating PUSH/POP on every cycle for 100 cycles against a reference LIFO model → top, nos and count match every cycle.
- Assert `rst` asynchronously between edges with count=5 and err_sticky=1 → all outputs at reset values before the next clk edge; PUSH 0x11 afterward → top=0x11, count=1.
